// File: rtl/nv_nvdla_mcif_read_eg_ret_unpack_if.sv
// Handshake bundle between the MCIF read-egress latency FIFO, the return unpacker and the client DMA.
// The master modport is the unpacker side; the slave modport is the FIFO/client environment side.
interface nv_nvdla_mcif_read_eg_ret_unpack_if #(
    parameter int DW = 256,
    parameter int MW = 2
);
    logic                 rq_rd_pvld;
    logic                 rq_rd_prdy;
    logic [2*DW+MW-1:0]   rq_rd_pd;
    logic                 dma_rd_rsp_pvld;
    logic                 dma_rd_rsp_prdy;
    logic [DW:0]          dma_rd_rsp_pd;
    logic                 unpack_err;

    modport master (
        input  rq_rd_pvld,
        input  rq_rd_pd,
        input  dma_rd_rsp_prdy,
        output rq_rd_prdy,
        output dma_rd_rsp_pvld,
        output dma_rd_rsp_pd,
        output unpack_err
    );

    modport slave (
        output rq_rd_pvld,
        output rq_rd_pd,
        output dma_rd_rsp_prdy,
        input  rq_rd_prdy,
        input  dma_rd_rsp_pvld,
        input  dma_rd_rsp_pd,
        input  unpack_err
    );
endinterface

// File: rtl/nv_nvdla_mcif_read_eg_ret_unpack.sv
// Unpacks 2*DW-bit latency-FIFO entries into DW-bit client beats (low half first, invalid halves skipped).
// Optional MCIF_EG_UNPACK_CNT_EN adds a saturating popped-beat counter on dbg_beat_cnt.
module nv_nvdla_mcif_read_eg_ret_unpack #(
    parameter int DW = 256,
    parameter int MW = 2
) (
    input  logic nvdla_core_clk,
    input  logic nvdla_core_rst,
    nv_nvdla_mcif_read_eg_ret_unpack_if.master io
`ifdef MCIF_EG_UNPACK_CNT_EN
    ,
    output logic [31:0] dbg_beat_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2
    } state_t;

    state_t          state_p0;
    state_t          state_nxt;
    logic [2*DW-1:0] hold_data_p0;
    logic [MW-1:0]   hold_mask_p0;
    logic            err_p0;

    logic [MW-1:0]   in_mask;
    logic [2*DW-1:0] in_data;
    logic            in_acc;
    logic            out_vld;
    logic            out_last;
    logic            out_pop;
    logic            out_last_pop;
    logic [DW-1:0]   out_data;

    assign in_mask = io.rq_rd_pd[2*DW +: MW];
    assign in_data = io.rq_rd_pd[2*DW-1:0];
    assign in_acc  = io.rq_rd_pvld && io.rq_rd_prdy;

    // Stage p0: the single holding entry, its FSM state and the empty-entry error flag
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            state_p0     <= IDLE;
            hold_data_p0 <= '0;
            hold_mask_p0 <= '0;
            err_p0       <= 1'b0;
        end else begin
            state_p0 <= state_nxt;
            err_p0   <= in_acc && (in_mask == '0);
            if (in_acc) begin
                hold_data_p0 <= in_data;
                hold_mask_p0 <= in_mask;
            end
        end
    end

    always_comb begin
        state_nxt = state_p0;
        if (in_acc) begin
            if (in_mask[0]) begin
                state_nxt = LO;
            end else if (in_mask[1]) begin
                state_nxt = HI;
            end else begin
                state_nxt = IDLE;
            end
        end else if (out_pop && (state_p0 == LO) && hold_mask_p0[1]) begin
            state_nxt = HI;
        end else if (out_last_pop) begin
            state_nxt = IDLE;
        end
    end

    // A new entry is taken in the same cycle the previous one's last beat leaves, so there is no bubble
    always_comb begin
        out_vld  = (state_p0 != IDLE);
        out_last = (state_p0 == HI) || ((state_p0 == LO) && !hold_mask_p0[1]);
        out_data = '0;
        case (state_p0)
            LO:      out_data = hold_data_p0[DW-1:0];
            HI:      out_data = hold_data_p0[2*DW-1:DW];
            default: out_data = '0;
        endcase
        out_pop      = out_vld && io.dma_rd_rsp_prdy;
        out_last_pop = out_pop && out_last;

        io.dma_rd_rsp_pvld = out_vld;
        io.dma_rd_rsp_pd   = out_vld ? {out_last, out_data} : '0;
        io.rq_rd_prdy      = !nvdla_core_rst && ((state_p0 == IDLE) || out_last_pop);
        io.unpack_err      = err_p0;
    end

`ifdef MCIF_EG_UNPACK_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] val);
        return (val == 32'hFFFF_FFFF) ? val : val + 32'd1;
    endfunction

    // Stage p0: debug beat counter, sticks at all-ones
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            dbg_beat_cnt <= '0;
        end else if (out_pop) begin
            dbg_beat_cnt <= sat_inc(dbg_beat_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_nv_nvdla_mcif_read_eg_ret_unpack.sv
// Directed table-driven bench for the read-egress return unpacker, plus reset-mid-entry and counter sequences.
module tb_nv_nvdla_mcif_read_eg_ret_unpack;
    localparam int DW = 256;
    localparam int MW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    nv_nvdla_mcif_read_eg_ret_unpack_if #(.DW(DW), .MW(MW)) io ();

`ifdef MCIF_EG_UNPACK_CNT_EN
    logic [31:0] dbg_beat_cnt;
`endif

    nv_nvdla_mcif_read_eg_ret_unpack #(.DW(DW), .MW(MW)) dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rst (rst),
        .io             (io.master)
`ifdef MCIF_EG_UNPACK_CNT_EN
        ,
        .dbg_beat_cnt   (dbg_beat_cnt)
`endif
    );

    typedef struct packed {
        logic       vld;
        logic [1:0] mask;
        logic [7:0] id;
        logic       rdy;
        logic       e_prdy;
        logic       e_ovld;
        logic       e_last;
        logic [7:0] e_tag;
        logic       e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic vld, input logic [1:0] mask, input logic [7:0] id,
                                input logic rdy, input logic e_prdy, input logic e_ovld,
                                input logic e_last, input logic [7:0] e_tag, input logic e_err);
        vec_t v;
        v = '{vld, mask, id, rdy, e_prdy, e_ovld, e_last, e_tag, e_err};
        return v;
    endfunction

    function automatic logic [DW-1:0] half(input logic [7:0] tag);
        return {(DW/8){tag}};
    endfunction

    function automatic logic [2*DW+MW-1:0] junk();
        logic [2*DW+MW-1:0] j;
        j = '0;
        for (int k = 0; k < (2*DW+MW+31)/32; k++) begin
            j = {j[2*DW+MW-33:0], 32'($urandom)};
        end
        return j;
    endfunction

    task automatic drive(input logic vld, input logic [1:0] mask, input logic [7:0] id, input logic rdy);
        io.rq_rd_pvld      = vld;
        io.dma_rd_rsp_prdy = rdy;
        if (vld) begin
            io.rq_rd_pd = {mask, half({id[6:0], 1'b1}), half({id[6:0], 1'b0})};
        end else begin
            io.rq_rd_pd = junk();
        end
    endtask

    task automatic chk(input string name, input logic [DW:0] act, input logic [DW:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_beat(input string name, input logic ovld, input logic last, input logic [7:0] tag);
        chk({name, " pvld"}, (DW+1)'(io.dma_rd_rsp_pvld), (DW+1)'(ovld));
        chk({name, " pd"}, io.dma_rd_rsp_pd, ovld ? {last, half(tag)} : '0);
    endtask

    initial begin
        io.rq_rd_pvld      = 1'b0;
        io.rq_rd_pd        = '0;
        io.dma_rd_rsp_prdy = 1'b0;

        vecs.push_back(mk(0, 2'b00, 8'd0, 1, 1, 0, 0, 8'd0, 0));
        vecs.push_back(mk(1, 2'b11, 8'd1, 1, 1, 0, 0, 8'd0, 0));
        vecs.push_back(mk(0, 2'b00, 8'd0, 1, 0, 1, 0, 8'd2, 0));
        vecs.push_back(mk(0, 2'b00, 8'd0, 1, 1, 1, 1, 8'd3, 0));
        vecs.push_back(mk(0, 2'b00, 8'd0, 1, 1, 0, 0, 8'd0, 0));
        vecs.push_back(mk(1, 2'b01, 8'd2, 1, 1, 0, 0, 8'd0, 0));
        vecs.push_back(mk(1, 2'b10, 8'd3, 1, 1, 1, 1, 8'd4, 0));
        vecs.push_back(mk(0, 2'b00, 8'd0, 1, 1, 1, 1, 8'd7, 0));
        vecs.push_back(mk(0, 2'b00, 8'd0, 1, 1, 0, 0, 8'd0, 0));
        vecs.push_back(mk(1, 2'b00, 8'd4, 1, 1, 0, 0, 8'd0, 0));
        vecs.push_back(mk(1, 2'b11, 8'd5, 1, 1, 0, 0, 8'd0, 1));
        vecs.push_back(mk(0, 2'b00, 8'd0, 1, 0, 1, 0, 8'd10, 0));
        vecs.push_back(mk(0, 2'b00, 8'd0, 1, 1, 1, 1, 8'd11, 0));
        vecs.push_back(mk(0, 2'b00, 8'd0, 1, 1, 0, 0, 8'd0, 0));
        vecs.push_back(mk(1, 2'b11, 8'd6, 0, 1, 0, 0, 8'd0, 0));
        for (int k = 0; k < 5; k++) begin
            vecs.push_back(mk(1, 2'b11, 8'd7, 0, 0, 1, 0, 8'd12, 0));
        end
        vecs.push_back(mk(1, 2'b11, 8'd7, 1, 0, 1, 0, 8'd12, 0));
        vecs.push_back(mk(1, 2'b11, 8'd7, 1, 1, 1, 1, 8'd13, 0));
        vecs.push_back(mk(0, 2'b00, 8'd0, 1, 0, 1, 0, 8'd14, 0));
        vecs.push_back(mk(0, 2'b00, 8'd0, 1, 1, 1, 1, 8'd15, 0));
        vecs.push_back(mk(0, 2'b00, 8'd0, 1, 1, 0, 0, 8'd0, 0));

        // Reset state
        @(negedge clk);
        #1;
        chk("reset prdy", (DW+1)'(io.rq_rd_prdy), '0);
        chk_beat("reset", 1'b0, 1'b0, 8'd0);
        chk("reset err", (DW+1)'(io.unpack_err), '0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            if (i != 0) @(negedge clk);
            drive(vecs[i].vld, vecs[i].mask, vecs[i].id, vecs[i].rdy);
            #1;
            chk($sformatf("row%0d prdy", i), (DW+1)'(io.rq_rd_prdy), (DW+1)'(vecs[i].e_prdy));
            chk_beat($sformatf("row%0d", i), vecs[i].e_ovld, vecs[i].e_last, vecs[i].e_tag);
            chk($sformatf("row%0d err", i), (DW+1)'(io.unpack_err), (DW+1)'(vecs[i].e_err));
        end

        // Reset asserted while the high half is pending
        @(negedge clk);
        drive(1'b1, 2'b11, 8'd8, 1'b0);
        @(negedge clk);
        drive(1'b0, 2'b00, 8'd0, 1'b1);
        #1;
        chk_beat("midrst lo", 1'b1, 1'b0, 8'd16);
        @(negedge clk);
        drive(1'b0, 2'b00, 8'd0, 1'b0);
        #1;
        chk_beat("midrst hi", 1'b1, 1'b1, 8'd17);
        #2;
        rst = 1'b1;
        #1;
        chk_beat("in rst", 1'b0, 1'b0, 8'd0);
        chk("in rst prdy", (DW+1)'(io.rq_rd_prdy), '0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 2'b00, 8'd0, 1'b1);
        #1;
        chk_beat("post rst", 1'b0, 1'b0, 8'd0);
        chk("post rst prdy", (DW+1)'(io.rq_rd_prdy), (DW+1)'(1'b1));
        @(negedge clk);
        drive(1'b1, 2'b01, 8'd9, 1'b1);
        #1;
        chk_beat("post rst idle", 1'b0, 1'b0, 8'd0);
        @(negedge clk);
        drive(1'b0, 2'b00, 8'd0, 1'b1);
        #1;
        chk_beat("recover", 1'b1, 1'b1, 8'd18);
        @(negedge clk);
        #1;
        chk_beat("recover idle", 1'b0, 1'b0, 8'd0);

`ifdef MCIF_EG_UNPACK_CNT_EN
        rst = 1'b1;
        #1;
        chk("cnt reset", (DW+1)'(dbg_beat_cnt), '0);
        @(negedge clk);
        rst = 1'b0;
        for (int e = 0; e < 4; e++) begin
            drive(1'b1, (e == 3) ? 2'b01 : 2'b11, 8'(20 + e), 1'b1);
            @(negedge clk);
            drive(1'b0, 2'b00, 8'd0, 1'b1);
            @(negedge clk);
            @(negedge clk);
            @(negedge clk);
        end
        #1;
        chk("cnt beats", (DW+1)'(dbg_beat_cnt), (DW+1)'(32'd7));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
